// File: rtl/mxrv_id_fetch_operand_pkg.sv
// Shared definitions for the mxrv decode-side operand fetch stage:
// reset polarity, zero constant, RV32 opcodes and the stage FSM encoding.
package mxrv_id_fetch_operand_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    CAP   = 2'd2,
    VALID = 2'd3
  } state_e;

  // Opcodes whose result is written back to rd.
  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mxrv_id_fetch_operand_if.sv
// Pipeline-facing handshakes of the operand fetch stage: instruction in from
// fetch, operand bundle out to execute. slave = the stage, master = its neighbours.
interface mxrv_id_fetch_operand_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);

  logic [XLEN-1:0]    inst_i;
  logic [XLEN-1:0]    inst_addr_i;
  logic               inst_valid_i;
  logic               inst_ready_o;

  logic               op_valid_o;
  logic               op_ready_i;
  logic [XLEN-1:0]    op_inst_o;
  logic [XLEN-1:0]    op_inst_addr_o;
  logic [XLEN-1:0]    op1_o;
  logic [XLEN-1:0]    op2_o;
  logic [XLEN-1:0]    imm_o;
  logic [RADDR_W-1:0] rd_addr_o;
  logic               rd_we_o;

  modport master (
    output inst_i, inst_addr_i, inst_valid_i, op_ready_i,
    input  inst_ready_o, op_valid_o, op_inst_o, op_inst_addr_o,
           op1_o, op2_o, imm_o, rd_addr_o, rd_we_o
  );

  modport slave (
    input  inst_i, inst_addr_i, inst_valid_i, op_ready_i,
    output inst_ready_o, op_valid_o, op_inst_o, op_inst_addr_o,
           op1_o, op2_o, imm_o, rd_addr_o, rd_we_o
  );

endinterface

// File: rtl/mxrv_imm_gen.sv
// Combinational RV32 immediate decoder; the sign bit is always inst[31].
module mxrv_imm_gen
  import mxrv_id_fetch_operand_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves imm unassigned (no latch).
    imm = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
      OPC_STORE:
        imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'h000};
      OPC_JAL:
        imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/mxrv_id_fetch_operand.sv
// Decode-side operand fetch: latches one instruction, reads rs1/rs2 from a
// registered register file that drops reads during writes, presents the bundle.
module mxrv_id_fetch_operand
  import mxrv_id_fetch_operand_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  mxrv_id_fetch_operand_if.slave pipe,
  output logic [RADDR_W-1:0]     rs1_addr_o,
  output logic [RADDR_W-1:0]     rs2_addr_o,
  input  logic [XLEN-1:0]        rs1_reg_data_i,
  input  logic [XLEN-1:0]        rs2_reg_data_i,
  input  logic                   wb_we_i,
  input  logic [RADDR_W-1:0]     wb_rd_addr_i,
  input  logic [XLEN-1:0]        wb_rd_data_i
);

  state_e             state;
  logic [XLEN-1:0]    inst_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    imm_q;
  logic [XLEN-1:0]    op1_q;
  logic [XLEN-1:0]    op2_q;
  logic [RADDR_W-1:0] rs1_q;
  logic [RADDR_W-1:0] rs2_q;
  logic [RADDR_W-1:0] rd_q;
  logic               rd_we_q;
  logic               op_valid_q;

  logic [XLEN-1:0]    imm_dec;
  logic [RADDR_W-1:0] rs1_dec;
  logic [RADDR_W-1:0] rs2_dec;
  logic [RADDR_W-1:0] rd_dec;
  logic               inst_ready;
  logic               accept;
  logic [XLEN-1:0]    op1_next;
  logic [XLEN-1:0]    op2_next;

  mxrv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (pipe.inst_i),
    .imm  (imm_dec)
  );

  assign rs1_dec = pipe.inst_i[15 +: RADDR_W];
  assign rs2_dec = pipe.inst_i[20 +: RADDR_W];
  assign rd_dec  = pipe.inst_i[7 +: RADDR_W];

  // A new instruction may enter while the current bundle is being handed off.
  assign inst_ready = (state == IDLE) || ((state == VALID) && pipe.op_ready_i);
  assign accept     = pipe.inst_valid_i && inst_ready;

  // x0 is a real storage location in the register file, so zero is forced here;
  // a write landing in CAP never reached the array read, so it is forwarded.
  always_comb begin
    op1_next = rs1_reg_data_i;
    op2_next = rs2_reg_data_i;
    if (rs1_q == '0)
      op1_next = '0;
    else if (wb_we_i && (wb_rd_addr_i == rs1_q))
      op1_next = wb_rd_data_i;
    if (rs2_q == '0)
      op2_next = '0;
    else if (wb_we_i && (wb_rd_addr_i == rs2_q))
      op2_next = wb_rd_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state      <= IDLE;
      inst_q     <= XLEN'(ZeroWord);
      pc_q       <= XLEN'(ZeroWord);
      imm_q      <= XLEN'(ZeroWord);
      op1_q      <= XLEN'(ZeroWord);
      op2_q      <= XLEN'(ZeroWord);
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      op_valid_q <= 1'b0;
    end else if (flush_i) begin
      state      <= IDLE;
      op_valid_q <= 1'b0;
    end else if (accept) begin
      inst_q     <= pipe.inst_i;
      pc_q       <= pipe.inst_addr_i;
      imm_q      <= imm_dec;
      rs1_q      <= rs1_dec;
      rs2_q      <= rs2_dec;
      rd_q       <= rd_dec;
      rd_we_q    <= writes_rd(pipe.inst_i[6:0]) && (rd_dec != '0);
      op_valid_q <= 1'b0;
      state      <= RD;
    end else begin
      case (state)
        // A write in this cycle suppresses the array read, so hold the address and retry.
        RD: if (!wb_we_i) state <= CAP;
        CAP: begin
          op1_q      <= op1_next;
          op2_q      <= op2_next;
          op_valid_q <= 1'b1;
          state      <= VALID;
        end
        VALID: if (pipe.op_ready_i) begin
          op_valid_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rs1_addr_o          = rs1_q;
  assign rs2_addr_o          = rs2_q;
  assign pipe.inst_ready_o   = inst_ready;
  assign pipe.op_valid_o     = op_valid_q;
  assign pipe.op_inst_o      = inst_q;
  assign pipe.op_inst_addr_o = pc_q;
  assign pipe.op1_o          = op1_q;
  assign pipe.op2_o          = op2_q;
  assign pipe.imm_o          = imm_q;
  assign pipe.rd_addr_o      = rd_q;
  assign pipe.rd_we_o        = rd_we_q;

endmodule
